univ_shift_reg: RTL
===================

# univ_shift_reg

Parametrised universal shift register: a generalised successor to the four-bit 194-style part. It adds configurable width, rotate and arithmetic-shift modes, a synchronous clear op, a clock enable and a counted burst-shift sequencer with busy/done handshake. It sits in the datapath wherever serial/parallel conversion or multi-step shifting is needed, for example display scan or body-segment shift chains.

## Interface
- WIDTH, 8, register width in bits (≥2); q[WIDTH-1] is the MSB ("A" end).
- CNT_W, 4, burst count width; must hold WIDTH (≥ $clog2(WIDTH)+1).

- clk  in  1  rising-edge clock; the only clock.
- clear  in  1  reset, synchronous, active-high; overrides everything.
- en  in  1  clock enable; low = hold all state, including the burst counter.
- op  in  3  operation: 0 HOLD, 1 SHR, 2 SHL, 3 LOAD, 4 ROR, 5 ROL, 6 ASR, 7 CLR.
- start  in  1  begin a counted burst of op.
- count  in  CNT_W  number of steps for a burst.
- sr  in  1  serial input entering at MSB on SHR.
- sl  in  1  serial input entering at LSB on SHL.
- d  in  WIDTH  parallel load data.
- q  out  WIDTH  register contents.
- so_r  out  1  q[0], combinational.
- so_l  out  1  q[WIDTH-1], combinational.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse when a burst completes.

## Operation
- Step semantics (one edge):
  - SHR: q ← {sr, q[W-1:1]}.
  - SHL: q ← {q[W-2:0], sl}.
  - ROR: q ← {q[0], q[W-1:1]}.
  - ROL: q ← {q[W-2:0], q[W-1]}.
  - ASR: q ← {q[W-1], q[W-1:1]}.
  - LOAD: q ← d.
  - CLR: q ← 0.
  - HOLD: no change.
- Idle mode (busy=0, start=0, en=1): op executes one step on every edge.
- Burst start (busy=0, start=1, en=1), with op and count latched:
  - count=0: no step; done=1 next cycle.
  - op ∈ {HOLD, LOAD, CLR}: one step, count ignored; done=1 next cycle.
  - Shift/rotate op with count=1: one step; done=1 next cycle.
  - Shift/rotate op with count>1: first step executes; remaining ← count-1; busy ← 1.
- Busy state: each en=1 edge performs the latched op. The op, start and count inputs are ignored; sr/sl are sampled live on every step. On the edge where remaining=1, the last step executes, busy ← 0 and done ← 1.
- start while busy is ignored and is not queued.
- en=0 while busy stalls the burst with no step and no decrement. done, if set, still clears after one cycle.
- FSM states: IDLE and RUN. done is a registered output, not a state.
- clear=1 on any edge: q=0, busy=0, done=0, remaining=0. An in-flight burst is aborted with no done pulse.

## Timing
- Reset values: q=0, busy=0, done=0, so_r=0, so_l=0.
- Step latency: q updates on the same edge that samples op.
- A burst of N≥1 shift steps completes in N enabled edges. busy is high for N-1 cycles (0 when N=1). done is high for exactly the one cycle after the final step.
- A new start is accepted in the cycle where done=1, giving back-to-back bursts with no gap.
- so_r and so_l track q with no additional delay.

## Structure
- Shared package: op encoding localparams (OP_HOLD … OP_CLR) and FSM state encoding, so that sequencers issuing ops import the same constants.
- Sub-module `univ_shift_step`: purely combinational next-value function (q, op, sr, sl, d → q_next). The top holds the register, counter and FSM. The same step unit is reusable for a future multi-bit barrel variant.

## Test plan
All scenarios use WIDTH=8.
- Reset: clear=1 for 2 cycles with arbitrary inputs → q=0x00, busy=0, done=0. Then LOAD with d=0xA5 → q=0xA5 after 1 edge.
- Idle shifts from 0xA5:
  - SHR with sr=1 → 0xD2.
  - Then SHL with sl=0 → 0xA4.
  - Then ASR → 0xD2.
  - en=0 holds 0xD2.
- Rotate burst: q=0x81, op=ROR, count=3, start pulse → q goes 0xC0, 0x60, 0x30 on successive edges; busy high for 2 cycles; done high 1 cycle after 0x30 appears.
- Stall and ignored start: q=0x80, ASR count=4, en=0 for 2 cycles mid-burst → final q=0xF8 after 6 edges. A start issued while busy has no effect.
- Abort: ROL count=5 on 0x01, clear asserted after 2 steps → q=0x00, busy=0, no done pulse.
- Boundaries:
  - count=0 start → done pulse, q unchanged.
  - count=8 ROR on 0x5A → q=0x5A again.
  - Start in the done cycle → second burst begins immediately.

Source files
------------

// File: rtl/univ_shift_reg_pkg.sv
// univ_shift_reg_pkg
// Purpose: constants shared by the universal shift register and by any
//          sequencer that issues operations to it. This covers the operation
//          encoding, the burst FSM state encoding, and a classifier telling
//          which operations may be repeated in a counted burst.
// Ports:   none (package).
package univ_shift_reg_pkg;

  // Operation encoding on the 3-bit op bus
  localparam logic [2:0] OP_HOLD = 3'd0;
  localparam logic [2:0] OP_SHR  = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_LOAD = 3'd3;
  localparam logic [2:0] OP_ROR  = 3'd4;
  localparam logic [2:0] OP_ROL  = 3'd5;
  localparam logic [2:0] OP_ASR  = 3'd6;
  localparam logic [2:0] OP_CLR  = 3'd7;

  // Burst sequencer states
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  // True for the ops whose repetition is meaningful (shifts and rotates).
  // HOLD, LOAD and CLR give the same result after one step as after many,
  // so a burst of them collapses to a single step.
  function automatic logic is_shift_op(input logic [2:0] op);
    logic res;
    case (op)
      OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_ASR: res = 1'b1;
      OP_HOLD, OP_LOAD, OP_CLR:               res = 1'b0;
      default:                                res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/univ_shift_step.sv
// univ_shift_step
// Purpose: purely combinational single-step next-value function of the
//          universal shift register. It holds no state, so it can be chained
//          or replicated later for a multi-bit barrel variant.
// Ports:
//   q_i      current register contents (q_i[WIDTH-1] is the MSB)
//   op_i     operation code (see univ_shift_reg_pkg)
//   sr_i     serial bit entering at the MSB on SHR
//   sl_i     serial bit entering at the LSB on SHL
//   d_i      parallel load data
//   q_next_o register value after one step of op_i
module univ_shift_step
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [2:0]       op_i,
  input  logic             sr_i,
  input  logic             sl_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_next_o
);

  // Next-value mux over all eight operations
  always_comb begin
    q_next_o = q_i;
    case (op_i)
      OP_HOLD: q_next_o = q_i;
      OP_SHR:  q_next_o = {sr_i, q_i[WIDTH-1:1]};
      OP_SHL:  q_next_o = {q_i[WIDTH-2:0], sl_i};
      OP_LOAD: q_next_o = d_i;
      OP_ROR:  q_next_o = {q_i[0], q_i[WIDTH-1:1]};
      OP_ROL:  q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      OP_ASR:  q_next_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
      OP_CLR:  q_next_o = {WIDTH{1'b0}};
      default: q_next_o = q_i;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg
// Purpose: parametrised universal shift register with a clock enable, a
//          synchronous clear, and a counted burst sequencer (IDLE/RUN) that
//          repeats a latched shift/rotate op for `count` enabled edges.
// Ports:
//   clk    rising-edge clock
//   clear  synchronous active-high reset, overrides everything
//   en     clock enable; low freezes register, counter and FSM
//   op     operation code (see univ_shift_reg_pkg)
//   start  begin a counted burst of op (ignored while busy)
//   count  number of burst steps
//   sr/sl  serial inputs for SHR (MSB end) / SHL (LSB end)
//   d      parallel load data
//   q      register contents (registered)
//   so_r   q[0], so_l q[WIDTH-1] (combinational taps of q)
//   busy   burst in progress (registered)
//   done   one-cycle pulse after the final burst step (registered)
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             sr,
  input  logic             sl,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             so_r,
  output logic             so_l,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] q_q,     q_d;
  logic             state_q, state_d;
  logic [2:0]       op_q,    op_d;
  logic [CNT_W-1:0] rem_q,   rem_d;
  logic             done_q,  done_d;

  logic [2:0]       step_op_s;
  logic [WIDTH-1:0] step_q_s;

  // While running, the latched op drives the step unit; otherwise the live op
  // does. One step unit serves both idle single steps and burst steps.
  always_comb begin
    if (state_q == ST_RUN) begin
      step_op_s = op_q;
    end else begin
      step_op_s = op;
    end
  end

  univ_shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .q_i      (q_q),
    .op_i     (step_op_s),
    .sr_i     (sr),
    .sl_i     (sl),
    .d_i      (d),
    .q_next_o (step_q_s)
  );

  // Next-state logic for the register, burst counter, FSM and done pulse
  always_comb begin
    q_d     = q_q;
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    done_d  = 1'b0;                 // done is a single-cycle pulse, even under en=0
    if (!en) begin
      q_d     = q_q;
      state_d = state_q;
    end else if (state_q == ST_RUN) begin
      q_d = step_q_s;
      if (rem_q == CNT_ONE) begin
        state_d = ST_IDLE;
        rem_d   = CNT_ZERO;
        done_d  = 1'b1;
      end else begin
        rem_d = rem_q - CNT_ONE;
      end
    end else if (start) begin
      op_d = op;
      if (count == CNT_ZERO) begin
        q_d    = q_q;               // empty burst: no step, only the done pulse
        done_d = 1'b1;
      end else if (!is_shift_op(op) || (count == CNT_ONE)) begin
        q_d    = step_q_s;
        done_d = 1'b1;
      end else begin
        // First step happens now; rem_q counts the steps still to go
        q_d     = step_q_s;
        rem_d   = count - CNT_ONE;
        state_d = ST_RUN;
      end
    end else begin
      q_d = step_q_s;
    end
  end

  // State registers with synchronous clear (aborts any burst without done)
  always_ff @(posedge clk) begin
    if (clear) begin
      q_q     <= {WIDTH{1'b0}};
      state_q <= ST_IDLE;
      op_q    <= OP_HOLD;
      rem_q   <= CNT_ZERO;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign so_r = q_q[0];
  assign so_l = q_q[WIDTH-1];
  assign busy = (state_q == ST_RUN);
  assign done = done_q;

endmodule
